// File: rtl/branch_predictor_if.sv
// Fetch-lookup and Execute-update signals between the core pipeline and the branch predictor.
// The core side is master and the predictor is slave.
interface branch_predictor_if;
  logic [31:0] pcF;
  logic        predictionF;
  logic [31:0] pc_predF;
  logic        BranchE;
  logic [31:0] pcE;
  logic        BtakenE;
  logic [31:0] pc_targetE;
  logic        predictionE;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  modport master (
    output pcF, BranchE, pcE, BtakenE, pc_targetE, predictionE,
    input  predictionF, pc_predF, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  pcF, BranchE, pcE, BtakenE, pc_targetE, predictionE,
    output predictionF, pc_predF, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch history/target table of 2-bit saturating counters with
// combinational Fetch lookup, Execute write-back and branch/mispredict statistics.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8
) (
  input  logic               clk,
  input  logic               reset,
  branch_predictor_if.slave  bus
);
  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [1:0]          ctr_d    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [31:0]         target_d [ENTRIES];
  logic [31:0]         branch_cnt_q, branch_cnt_d;
  logic [31:0]         mispredict_cnt_q, mispredict_cnt_d;

  logic [INDEX_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0]   tag_f, tag_e;
  logic                  hit_f, hit_e;

  assign idx_f = bus.pcF[INDEX_BITS+1:2];
  assign tag_f = bus.pcF[INDEX_BITS+2 +: TAG_BITS];
  assign idx_e = bus.pcE[INDEX_BITS+1:2];
  assign tag_e = bus.pcE[INDEX_BITS+2 +: TAG_BITS];

  // PC bits outside index and tag never influence the table
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pcF[1:0], bus.pcF[31:INDEX_BITS+2+TAG_BITS],
                            bus.pcE[1:0], bus.pcE[31:INDEX_BITS+2+TAG_BITS]};

  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  // Lookup reads registered state only, so a same-cycle update is not bypassed
  assign bus.predictionF    = hit_f && ctr_q[idx_f][1];
  assign bus.pc_predF       = bus.predictionF ? target_q[idx_f] : 32'h0;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;

  always_comb begin
    valid_d          = valid_q;
    tag_d            = tag_q;
    ctr_d            = ctr_q;
    target_d         = target_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (bus.BranchE) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
      if (bus.predictionE != bus.BtakenE)
        mispredict_cnt_d = mispredict_cnt_q + 32'd1;
      if (hit_e) begin
        if (bus.BtakenE) begin
          if (ctr_q[idx_e] != 2'b11)
            ctr_d[idx_e] = ctr_q[idx_e] + 2'd1;
          target_d[idx_e] = bus.pc_targetE;
        end else if (ctr_q[idx_e] != 2'b00) begin
          ctr_d[idx_e] = ctr_q[idx_e] - 2'd1;
        end
      end else if (bus.BtakenE) begin
        // Taken miss evicts whatever occupied this index
        valid_d[idx_e]  = 1'b1;
        tag_d[idx_e]    = tag_e;
        ctr_d[idx_e]    = 2'b10;
        target_d[idx_e] = bus.pc_targetE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q          <= '0;
      tag_q            <= '{default: '0};
      ctr_q            <= '{default: 2'b01};
      target_q         <= '{default: '0};
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      valid_q          <= valid_d;
      tag_q            <= tag_d;
      ctr_q            <= ctr_d;
      target_q         <= target_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, random traffic against an
// array-based reference model, and an asynchronous mid-run reset sequence.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  branch_predictor_if bus();

  branch_predictor #(.INDEX_BITS(6), .TAG_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  // Reference model: one record per table slot, counter kept as an integer 0..3
  bit          m_valid  [64];
  int unsigned m_tag    [64];
  int          m_ctr    [64];
  logic [31:0] m_target [64];
  logic [31:0] m_bcnt, m_mcnt;

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_target[i] = 32'h0;
    end
    m_bcnt = 0; m_mcnt = 0;
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    int i = int'((pc / 4) % 64);
    return m_valid[i] && (m_tag[i] == (pc / 256) % 256);
  endfunction

  function automatic logic m_pred(logic [31:0] pc);
    return m_hit(pc) && (m_ctr[(pc / 4) % 64] >= 2);
  endfunction

  function automatic logic [31:0] m_pp(logic [31:0] pc);
    return m_pred(pc) ? m_target[(pc / 4) % 64] : 32'h0;
  endfunction

  function automatic void m_update(logic [31:0] pc, logic taken, logic [31:0] tgt, logic pe);
    int i = int'((pc / 4) % 64);
    m_bcnt = m_bcnt + 1;
    if (pe != taken) m_mcnt = m_mcnt + 1;
    if (m_hit(pc)) begin
      if (taken) begin
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_target[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (taken) begin
      m_valid[i] = 1; m_tag[i] = (pc / 256) % 256; m_ctr[i] = 2; m_target[i] = tgt;
    end
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge: drive, check mid-cycle, then advance the model at the edge
  task automatic do_vec(string tag, logic [31:0] pcf, logic br, logic [31:0] pce,
                        logic bt, logic [31:0] tgt, logic pe);
    bus.pcF = pcf; bus.BranchE = br; bus.pcE = pce;
    bus.BtakenE = bt; bus.pc_targetE = tgt; bus.predictionE = pe;
    @(negedge clk);
    $display("%s pcF=%h br=%b pcE=%h bt=%b tgt=%h pe=%b -> pred=%b pp=%h cnt=%0d/%0d",
             tag, pcf, br, pce, bt, tgt, pe, bus.predictionF, bus.pc_predF,
             bus.branch_cnt, bus.mispredict_cnt);
    chk({tag, ".pred"}, {31'h0, bus.predictionF}, {31'h0, m_pred(pcf)});
    chk({tag, ".pp"}, bus.pc_predF, m_pp(pcf));
    chk({tag, ".bcnt"}, bus.branch_cnt, m_bcnt);
    chk({tag, ".mcnt"}, bus.mispredict_cnt, m_mcnt);
    @(posedge clk);
    if (br) m_update(pce, bt, tgt, pe);
    #1;
  endtask

  typedef struct {
    logic [31:0] pcf;
    logic        br;
    logic [31:0] pce;
    logic        bt;
    logic [31:0] tgt;
    logic        pe;
    logic        exp_pred;
    logic [31:0] exp_pp;
  } vec_t;

  vec_t tbl[22];

  initial begin
    //          pcF      br    pcE      bt    tgt      pe    pred  pp
    tbl[0]  = '{32'h040, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000};
    tbl[1]  = '{32'h040, 1'b1, 32'h040, 1'b1, 32'h080, 1'b0, 1'b0, 32'h000};
    tbl[2]  = '{32'h040, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b1, 32'h080};
    tbl[3]  = '{32'h040, 1'b1, 32'h040, 1'b1, 32'h080, 1'b1, 1'b1, 32'h080};
    tbl[4]  = '{32'h040, 1'b1, 32'h040, 1'b1, 32'h080, 1'b1, 1'b1, 32'h080};
    tbl[5]  = '{32'h040, 1'b1, 32'h040, 1'b0, 32'h0F0, 1'b1, 1'b1, 32'h080};
    tbl[6]  = '{32'h040, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b1, 32'h080};
    tbl[7]  = '{32'h040, 1'b1, 32'h040, 1'b0, 32'h0F0, 1'b1, 1'b1, 32'h080};
    tbl[8]  = '{32'h040, 1'b1, 32'h040, 1'b0, 32'h0F0, 1'b0, 1'b0, 32'h000};
    tbl[9]  = '{32'h040, 1'b1, 32'h040, 1'b0, 32'h0F0, 1'b0, 1'b0, 32'h000};
    tbl[10] = '{32'h040, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000};
    tbl[11] = '{32'h040, 1'b1, 32'h040, 1'b1, 32'h080, 1'b0, 1'b0, 32'h000};
    tbl[12] = '{32'h040, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000};
    tbl[13] = '{32'h040, 1'b1, 32'h040, 1'b1, 32'h084, 1'b0, 1'b0, 32'h000};
    tbl[14] = '{32'h040, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b1, 32'h084};
    tbl[15] = '{32'h140, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000};
    tbl[16] = '{32'h140, 1'b1, 32'h140, 1'b1, 32'h200, 1'b0, 1'b0, 32'h000};
    tbl[17] = '{32'h040, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000};
    tbl[18] = '{32'h140, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b1, 32'h200};
    tbl[19] = '{32'h140, 1'b1, 32'h240, 1'b0, 32'h300, 1'b0, 1'b1, 32'h200};
    tbl[20] = '{32'h140, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b1, 32'h200};
    tbl[21] = '{32'h240, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000};

    bus.pcF = 32'h40; bus.BranchE = 1'b0; bus.pcE = 32'h0;
    bus.BtakenE = 1'b0; bus.pc_targetE = 32'h0; bus.predictionE = 1'b0;
    m_reset();
    #2;
    chk("rst.pred", {31'h0, bus.predictionF}, 32'h0);
    chk("rst.pp", bus.pc_predF, 32'h0);
    chk("rst.bcnt", bus.branch_cnt, 32'h0);
    chk("rst.mcnt", bus.mispredict_cnt, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed table: allocation, saturation, same-cycle update, tag conflict
    for (int i = 0; i < 22; i++) begin
      bus.pcF = tbl[i].pcf;
      #1;
      chk($sformatf("tbl%0d.pred", i), {31'h0, bus.predictionF}, {31'h0, tbl[i].exp_pred});
      chk($sformatf("tbl%0d.pp", i), bus.pc_predF, tbl[i].exp_pp);
      do_vec($sformatf("tbl%0d", i), tbl[i].pcf, tbl[i].br, tbl[i].pce,
             tbl[i].bt, tbl[i].tgt, tbl[i].pe);
    end
    chk("tbl.bcnt", bus.branch_cnt, 32'd11);
    chk("tbl.mcnt", bus.mispredict_cnt, 32'd6);

    // Random traffic over a small aliasing-heavy PC set
    for (int i = 0; i < 300; i++) begin
      logic [31:0] pf, pe_pc, tg;
      pf    = ($urandom_range(0, 3) << 8) | ($urandom_range(14, 17) << 2);
      pe_pc = ($urandom_range(0, 3) << 8) | ($urandom_range(14, 17) << 2);
      tg    = $urandom & 32'hFFFF_FFFC;
      do_vec($sformatf("rnd%0d", i), pf, 1'($urandom_range(0, 2) != 0), pe_pc,
             1'($urandom), tg, 1'($urandom));
    end

    // Mid-run asynchronous reset with a coincident update strobe
    reset = 1'b1; m_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    do_vec("pop0", 32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
    do_vec("pop1", 32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1);
    do_vec("pop2", 32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1);
    do_vec("pop3", 32'h80, 1'b1, 32'h80, 1'b1, 32'hC0, 1'b0);
    do_vec("pop4", 32'h40, 1'b1, 32'h80, 1'b1, 32'hC0, 1'b1);
    chk("pop.pred", {31'h0, bus.predictionF}, 32'h1);
    chk("pop.bcnt", bus.branch_cnt, 32'd5);
    chk("pop.mcnt", bus.mispredict_cnt, 32'd2);
    bus.pcF = 32'h44; bus.BranchE = 1'b1; bus.pcE = 32'h44;
    bus.BtakenE = 1'b1; bus.pc_targetE = 32'h99C; bus.predictionE = 1'b0;
    #2;
    reset = 1'b1; m_reset();
    #1;
    $display("midrst pred=%b pp=%h cnt=%0d/%0d", bus.predictionF, bus.pc_predF,
             bus.branch_cnt, bus.mispredict_cnt);
    chk("midrst.pred", {31'h0, bus.predictionF}, 32'h0);
    chk("midrst.bcnt", bus.branch_cnt, 32'h0);
    chk("midrst.mcnt", bus.mispredict_cnt, 32'h0);
    bus.pcF = 32'h40;
    #1;
    chk("midrst.pred40", {31'h0, bus.predictionF}, 32'h0);
    chk("midrst.pp40", bus.pc_predF, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    do_vec("post0", 32'h44, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    do_vec("post1", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the pipelined RV32I core. Holds a direct-mapped branch history/target table of 2-bit saturating counters. In Fetch it looks up the current PC and supplies the taken prediction and predicted target that drive the predicted-target PC select. Execute writes each resolved conditional branch back into the table, and the block keeps branch and misprediction counters for performance measurement.

## Interface
Parameters:
- INDEX_BITS, 6: table index width; entries = 2**INDEX_BITS (64).
- TAG_BITS, 8: stored tag width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pcF  in  32  Fetch-stage PC.
- predictionF  out  1  predicted taken for pcF.
- pc_predF  out  32  predicted target for pcF; 0 when predictionF=0.
- BranchE  in  1  Execute holds a conditional branch this cycle; update strobe.
- pcE  in  32  PC of the branch in Execute.
- BtakenE  in  1  resolved outcome of that branch.
- pc_targetE  in  32  resolved branch target (pcE + imm).
- predictionE  in  1  prediction carried down the pipe with that branch.
- branch_cnt  out  32  number of resolved conditional branches.
- mispredict_cnt  out  32  number of direction mispredictions.

## Operation
- Index and tag:
  - idx = pc[INDEX_BITS+1:2].
  - tag = pc[INDEX_BITS+2 +: TAG_BITS]; with the defaults, idx = pc[7:2] and tag = pc[15:8].
- Each entry holds valid (1), tag (TAG_BITS), ctr (2), target (32).
- Lookup (combinational, from pcF):
  - hit = valid[idxF] && tag[idxF]==tagF.
  - predictionF = hit && ctr[idxF][1].
  - pc_predF = predictionF ? target[idxF] : 32'h0.
- Update at the rising edge when BranchE=1, using idxE/tagE from pcE:
  - Hit, BtakenE=1: ctr = min(ctr+1, 3); target = pc_targetE.
  - Hit, BtakenE=0: ctr = max(ctr-1, 0); target unchanged.
  - Miss (invalid or tag mismatch), BtakenE=1: allocate and overwrite the entry with valid=1, tag=tagE, ctr=2'b10, target=pc_targetE.
  - Miss, BtakenE=0: entry unchanged; no allocation.
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- Statistics, updated at the same edge:
  - branch_cnt += 1 when BranchE=1.
  - mispredict_cnt += 1 when BranchE=1 && predictionE != BtakenE.
  - Both wrap modulo 2**32.
- BranchE=0: table and counters hold; pcE, BtakenE, pc_targetE and predictionE are ignored.
- Only conditional branches use this block. JAL/JALR never update it.

## Timing
- Reset (asynchronous, immediate):
  - all valid=0, all ctr=2'b01, all target=0, all tag=0;
  - branch_cnt=0, mispredict_cnt=0;
  - so predictionF=0 and pc_predF=0 while reset is high and after release.
- Lookup latency: 0 cycles; outputs are combinational from pcF and registered table state.
- Update latency: 1 cycle; a write at edge N is visible to lookups from cycle N onward (after the edge).
- Simultaneous lookup and update of the same idx in one cycle:
  - the lookup returns the pre-update contents;
  - there is no write-to-read bypass.
- Aliasing: two PCs with the same idx and different tag share one entry. A taken branch on a miss evicts the current occupant; the loser's next lookup misses and predicts not-taken.
- Reset asserted mid-operation:
  - all state clears immediately;
  - an update strobe in the same cycle as reset is discarded.
- Stalls are handled upstream. BranchE must be high for exactly one cycle per branch; holding it high for k cycles counts and trains k times.

## Test plan
- Reset, then pcF=32'h0000_0040 -> predictionF=0, pc_predF=0, branch_cnt=0, mispredict_cnt=0.
- Allocation:
  - one update with pcE=32'h40, BtakenE=1, pc_targetE=32'h80, predictionE=0;
  - next cycle pcF=32'h40 -> predictionF=1, pc_predF=32'h80; ctr=10, branch_cnt=1, mispredict_cnt=1.
- Saturation, on the allocated 32'h40 entry:
  - two more taken updates -> ctr=11;
  - one not-taken update -> ctr=10, predictionF still 1;
  - two more not-taken updates -> ctr=00, predictionF=0;
  - a further not-taken update -> ctr stays 00.
- Tag conflict:
  - after allocating 32'h40, lookup pcF=32'h140 (same idx 16, tag 1 vs 0) -> predictionF=0;
  - a taken update at 32'h140 with target 32'h200 -> pcF=32'h40 now predicts 0, pcF=32'h140 predicts 1 with pc_predF=32'h200;
  - a not-taken update at a missing PC changes nothing.
- Same-cycle lookup and update at idx of 32'h40 (ctr=01, valid, BtakenE=1) -> that cycle predictionF=0; the following cycle predictionF=1.
- Reset mid-run: assert reset asynchronously between edges with a populated table and counts=5/2 -> outputs zero immediately; an update strobe coincident with reset has no effect after release.
